// File: rtl/mux8way_rr_merge.sv
// Eight-input round-robin stream merger with a registered output stage.
// Each channel offers a WIDTH-bit word under valid/ready; one word per cycle is
// granted and loaded into the output register, tagged with its source index
// (0 = channel a ... 7 = channel h).
module mux8way_rr_merge #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_valid,
  input  logic [WIDTH-1:0] in_data_a,
  input  logic [WIDTH-1:0] in_data_b,
  input  logic [WIDTH-1:0] in_data_c,
  input  logic [WIDTH-1:0] in_data_d,
  input  logic [WIDTH-1:0] in_data_e,
  input  logic [WIDTH-1:0] in_data_f,
  input  logic [WIDTH-1:0] in_data_g,
  input  logic [WIDTH-1:0] in_data_h,
  output logic [7:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_sel
);

  logic [WIDTH-1:0] data_arr [8];
  logic [2:0]       ptr;
  logic [2:0]       grant;
  logic             any_valid;
  logic             load_en;
  logic             transfer;

  assign data_arr[0] = in_data_a;
  assign data_arr[1] = in_data_b;
  assign data_arr[2] = in_data_c;
  assign data_arr[3] = in_data_d;
  assign data_arr[4] = in_data_e;
  assign data_arr[5] = in_data_f;
  assign data_arr[6] = in_data_g;
  assign data_arr[7] = in_data_h;

  // The output slot can accept a word when empty or when it drains this cycle.
  assign load_en   = !out_valid || out_ready;
  assign any_valid = |in_valid;
  assign transfer  = load_en && any_valid && !reset;

  // Round-robin search: first valid channel at or after ptr, wrapping 7 -> 0.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no
    // latch is inferred for paths that do not assign it.
    logic [2:0] idx;
    grant = '0;
    idx   = '0;
    // Walk offsets from farthest to nearest so the nearest valid channel wins.
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (in_valid[idx]) grant = idx;
    end
  end

  // Only the granted channel sees ready, and only when the slot can take it.
  always_comb begin
    in_ready = '0;
    if (transfer) in_ready[grant] = 1'b1;
  end

  // Output register and priority pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= data_arr[grant];
      out_sel   <= grant;
      ptr       <= grant + 3'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8way_rr_merge.sv
// Self-checking bench for mux8way_rr_merge: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_mux8way_rr_merge;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       in_valid;
  logic [WIDTH-1:0] data [8];
  logic [7:0]       in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_sel;

  int checks = 0;
  int failures = 0;

  // Reference model state: what the output slot holds and who is next in line.
  bit          m_valid;
  logic [15:0] m_data;
  int          m_sel;
  int          m_ptr;

  always #5 clk = ~clk;

  mux8way_rr_merge #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_data_a(data[0]), .in_data_b(data[1]), .in_data_c(data[2]),
    .in_data_d(data[3]), .in_data_e(data[4]), .in_data_f(data[5]),
    .in_data_g(data[6]), .in_data_h(data[7]),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  // First requesting channel in round-robin order from the model pointer, or -1.
  function automatic int model_grant();
    for (int k = 0; k < 8; k++)
      if (in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs: check ready mid-cycle,
  // advance the model, then check the registered outputs after the edge.
  task automatic step(input string tag);
    int          g;
    bit          room;
    logic [7:0]  exp_ready;
    room = !m_valid || out_ready;
    g = model_grant();
    exp_ready = 8'h00;
    if (!reset && room && g >= 0) exp_ready = 8'(1 << g);
    @(negedge clk);
    check({tag, ":in_ready"}, 32'(in_ready), 32'(exp_ready));
    if (reset) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (room && g >= 0) begin
      m_valid = 1; m_data = data[g]; m_sel = g; m_ptr = (g + 1) % 8;
    end else if (room) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check({tag, ":out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ":out_data"}, 32'(out_data), 32'(m_data));
    check({tag, ":out_sel"}, 32'(out_sel), 32'(m_sel));
  endtask

  initial begin
    reset = 1'b1; in_valid = 8'h00; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) data[i] = '0;
    m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;

    // Reset then idle.
    step("reset0");
    step("reset1");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("idle");

    // Single channel f.
    in_valid = 8'b0010_0000; data[5] = 16'hBEEF;
    step("single_f");
    check("single_f:const_data", 32'(out_data), 32'h0000_BEEF);
    check("single_f:const_sel", 32'(out_sel), 32'd5);
    in_valid = 8'h00;
    step("single_drain");

    // Round robin with all channels valid, starting from a fresh pointer.
    reset = 1'b1; step("rr_reset"); reset = 1'b0;
    in_valid = 8'hFF;
    for (int i = 0; i < 8; i++) data[i] = 16'(i);
    for (int i = 0; i < 10; i++) begin
      step("rr");
      check("rr:const_sel", 32'(out_sel), 32'(i % 8));
    end

    // Backpressure: a and c valid, stall after first load, then release.
    reset = 1'b1; in_valid = 8'h00; step("bp_reset"); reset = 1'b0;
    in_valid = 8'b0000_0101; data[0] = 16'hA0A0; data[2] = 16'hC2C2;
    step("bp_load_a");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("bp_stall");
    check("bp:frozen_sel", 32'(out_sel), 32'd0);
    out_ready = 1'b1;
    step("bp_load_c");
    check("bp:c_next", 32'(out_sel), 32'd2);
    step("bp_load_a2");
    check("bp:a_after", 32'(out_sel), 32'd0);

    // Pointer wrap: grant g leaves ptr=7, then a and b are served in order.
    reset = 1'b1; in_valid = 8'h00; step("wrap_reset"); reset = 1'b0;
    in_valid = 8'b0100_0000; step("wrap_g");
    in_valid = 8'b0000_0011; data[0] = 16'h1111; data[1] = 16'h2222;
    step("wrap_a");
    check("wrap:a_sel", 32'(out_sel), 32'd0);
    step("wrap_b");
    check("wrap:b_sel", 32'(out_sel), 32'd1);
    in_valid = 8'h00; step("wrap_idle");

    // Reset mid-stream while a word is pending.
    in_valid = 8'hFF;
    for (int i = 0; i < 4; i++) step("mid_stream");
    reset = 1'b1; step("mid_reset");
    check("mid_reset:valid_dropped", 32'(out_valid), 32'd0);
    reset = 1'b0; step("mid_first");
    check("mid_first:sel_a", 32'(out_sel), 32'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      in_valid = 8'($urandom);
      if ($urandom_range(3) == 0) in_valid = 8'h00;
      out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < 8; i++) data[i] = 16'($urandom);
      reset = ($urandom_range(49) == 0);
      step("random");
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8way_rr_merge.md
Name: mux8way_rr_merge

Overview:
- Eight-input, single-output stream merger; the collecting counterpart of the DMux8Way distribution path.
- Each of eight producer channels offers a WIDTH-bit word with a valid/ready handshake.
- A round-robin arbiter picks one word per cycle and loads it into a registered output stage, tagged with its 3-bit source index.
- The tag uses the same encoding as the DMux8Way sel input: a=0 ... h=7.

Parameters:
WIDTH, 16, data word width (Hack word).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  8  per-channel valid; bit 0 = channel a ... bit 7 = channel h.
in_data_a..in_data_h  input  WIDTH each  channel data words.
in_ready  output  8  per-channel accept; at most one bit high per cycle.
out_valid  output  1  output register holds a word.
out_ready  input  1  downstream accept.
out_data  output  WIDTH  merged word.
out_sel  output  3  source channel of out_data (0=a ... 7=h).

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high.
- Reset (sampled high at a clk edge):
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - in_ready=0 combinationally while reset is high.
- load_en = !out_valid || out_ready. This is combinational and gives a full-throughput pipeline with no bubble.
- Arbitration (combinational, every cycle):
  - Search in_valid starting at index ptr, ascending, wrapping 7->0.
  - The first set bit is grant index g.
  - in_ready[g] = load_en && any(in_valid) && !reset. All other in_ready bits are 0.
- Transfer into the output stage occurs when in_valid[g] && in_ready[g]. At the next clk edge:
  - out_data <= in_data_g, out_sel <= g, out_valid <= 1.
  - ptr <= (g+1) mod 8; the 3-bit wrap is natural.
- If load_en but no input is valid:
  - If out_ready && out_valid, then out_valid <= 0.
  - out_data and out_sel hold their last values.
  - ptr unchanged.
- If out_valid && !out_ready: out_valid, out_data, out_sel all hold; all in_ready=0; ptr unchanged.
- Simultaneous drain and load (out_valid && out_ready && a valid input): the old word leaves and the new word loads on the same edge. out_valid stays 1.
- Latency: word accepted at edge N appears on out_data after edge N; 1 cycle.
- Throughput: 1 word/cycle while out_ready=1.
- Fairness:
  - With all 8 channels continuously valid and out_ready=1, grants cycle a,b,...,h,a,...
  - A continuously valid channel waits at most 7 accepted transfers.
- ptr advances only on an accepted transfer, never on a stall or idle cycle.
- Producers must hold in_valid and data stable until accepted. The block does not check this.
- in_ready must not depend on in_valid of the same channel except through the grant search. No combinational path from out_ready to out_data.
- Reset mid-operation: a pending output word is discarded (out_valid=0), ptr returns to 0, and no in_ready is asserted in the reset cycle.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then all in_valid=0 and out_ready=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=8'h00 throughout.
- Single channel: in_valid=8'b0010_0000, in_data_f=16'hBEEF, out_ready=1 -> in_ready=8'b0010_0000 in the same cycle; next cycle out_valid=1, out_data=16'hBEEF, out_sel=5.
- Round robin, all channels valid: in_valid=8'hFF, in_data_x = channel index, out_ready=1 for 10 cycles -> out_sel sequence 0,1,...,7,0,1; out_data matches out_sel; one word per cycle.
- Backpressure: channels a and c valid, out_ready=0 after the first load -> out_data/out_sel frozen at a (0) and in_ready=0. Release out_ready -> c (2) loads next, then a.
- Pointer wrap and skip: ptr=7 (after granting g), in_valid=8'b0000_0011 -> grant a (0), then b (1); ptr ends at 2.
- Reset mid-stream: all channels valid, streaming; assert reset for 1 cycle while out_valid=1 -> out_valid=0 next cycle. After release, the first grant is channel a regardless of the prior ptr.
